// File: rtl/zx_key_matrix.sv
// PS/2 set-2 scancode tracker for the 40-key ZX Spectrum matrix with a registered port 0xFE read path.
// Optional: define ZX_KEY_CURSOR_EN for cursor/backspace composite keys (CAPS + digit).
module zx_key_matrix #(
   parameter int unsigned TIMEOUT_CYCLES = 27000,
   parameter int unsigned TO_W           = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic [7:0]  addr_hi,
   output logic [4:0]  kb_cols,
   output logic [39:0] key_matrix,
   output logic        key_event
);

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   state_t          state, state_nxt;
   logic [TO_W-1:0] to_cnt;
   logic            to_hit;
   logic            is_prefix, ext_ctx;
   logic            do_make, do_break, do_clear;
   logic [6:0]      map;
   logic [39:0]     matrix_nxt;
   logic [39:0]     eff;
   logic [4:0]      cols_nxt;
   logic            event_nxt;

   // Returns {valid, matrix index}; index = row*5 + col.
   function automatic logic [6:0] map_code(input logic [7:0] code, input logic ext);
      logic [6:0] m;
      m = '0;
      if (ext) begin
         if (code == 8'h14) m = {1'b1, 6'd36};
      end else begin
         case (code)
            8'h12, 8'h59: m = {1'b1, 6'd0};
            8'h1A: m = {1'b1, 6'd1};
            8'h22: m = {1'b1, 6'd2};
            8'h21: m = {1'b1, 6'd3};
            8'h2A: m = {1'b1, 6'd4};
            8'h1C: m = {1'b1, 6'd5};
            8'h1B: m = {1'b1, 6'd6};
            8'h23: m = {1'b1, 6'd7};
            8'h2B: m = {1'b1, 6'd8};
            8'h34: m = {1'b1, 6'd9};
            8'h15: m = {1'b1, 6'd10};
            8'h1D: m = {1'b1, 6'd11};
            8'h24: m = {1'b1, 6'd12};
            8'h2D: m = {1'b1, 6'd13};
            8'h2C: m = {1'b1, 6'd14};
            8'h16: m = {1'b1, 6'd15};
            8'h1E: m = {1'b1, 6'd16};
            8'h26: m = {1'b1, 6'd17};
            8'h25: m = {1'b1, 6'd18};
            8'h2E: m = {1'b1, 6'd19};
            8'h45: m = {1'b1, 6'd20};
            8'h46: m = {1'b1, 6'd21};
            8'h3E: m = {1'b1, 6'd22};
            8'h3D: m = {1'b1, 6'd23};
            8'h36: m = {1'b1, 6'd24};
            8'h4D: m = {1'b1, 6'd25};
            8'h44: m = {1'b1, 6'd26};
            8'h43: m = {1'b1, 6'd27};
            8'h3C: m = {1'b1, 6'd28};
            8'h35: m = {1'b1, 6'd29};
            8'h5A: m = {1'b1, 6'd30};
            8'h4B: m = {1'b1, 6'd31};
            8'h42: m = {1'b1, 6'd32};
            8'h3B: m = {1'b1, 6'd33};
            8'h33: m = {1'b1, 6'd34};
            8'h29: m = {1'b1, 6'd35};
            8'h14: m = {1'b1, 6'd36};
            8'h3A: m = {1'b1, 6'd37};
            8'h31: m = {1'b1, 6'd38};
            8'h32: m = {1'b1, 6'd39};
            default: m = '0;
         endcase
      end
      return m;
   endfunction

   assign is_prefix = (rx_data == 8'hF0) || (rx_data == 8'hE0);
   assign ext_ctx   = (state == EXT) || (state == EXT_BRK);
   assign to_hit    = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign map       = map_code(rx_data, ext_ctx);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         to_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (rx_valid || state == IDLE || to_hit) to_cnt <= '0;
         else                                     to_cnt <= to_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (rx_valid) begin
         case (state)
            IDLE: begin
               if (rx_data == 8'hF0)      state_nxt = BRK;
               else if (rx_data == 8'hE0) state_nxt = EXT;
            end
            BRK: begin
               if (rx_data == 8'hE0)       state_nxt = EXT_BRK;
               else if (rx_data != 8'hF0)  state_nxt = IDLE;
            end
            EXT: begin
               if (rx_data == 8'hF0)       state_nxt = EXT_BRK;
               else if (rx_data != 8'hE0)  state_nxt = IDLE;
            end
            EXT_BRK: begin
               if (!is_prefix)             state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end else if (to_hit) begin
         state_nxt = IDLE;
      end
   end

   always_comb begin
      do_make  = rx_valid && !is_prefix && (state == IDLE || state == EXT);
      do_break = rx_valid && !is_prefix && (state == BRK  || state == EXT_BRK);
      do_clear = rx_valid && (state == IDLE) && (rx_data == 8'h00 || rx_data == 8'hFF);
   end

   always_comb begin
      matrix_nxt = key_matrix;
      if (do_clear)                  matrix_nxt = '0;
      else if (map[6] && do_make)    matrix_nxt[map[5:0]] = 1'b1;
      else if (map[6] && do_break)   matrix_nxt[map[5:0]] = 1'b0;
   end

`ifdef ZX_KEY_CURSOR_EN
   logic [4:0] comp, comp_nxt;
   logic [3:0] cmap;

   // {valid, composite bit}: 0 Up(7) 1 Down(6) 2 Left(5) 3 Right(8) 4 Backspace(0)
   function automatic logic [3:0] cursor_code(input logic [7:0] code, input logic ext);
      logic [3:0] m;
      m = '0;
      if (ext) begin
         case (code)
            8'h75:   m = {1'b1, 3'd0};
            8'h72:   m = {1'b1, 3'd1};
            8'h6B:   m = {1'b1, 3'd2};
            8'h74:   m = {1'b1, 3'd3};
            default: m = '0;
         endcase
      end else if (code == 8'h66) begin
         m = {1'b1, 3'd4};
      end
      return m;
   endfunction

   assign cmap = cursor_code(rx_data, ext_ctx);

   always_comb begin
      comp_nxt = comp;
      if (do_clear)                 comp_nxt = '0;
      else if (cmap[3] && do_make)  comp_nxt[cmap[2:0]] = 1'b1;
      else if (cmap[3] && do_break) comp_nxt[cmap[2:0]] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) comp <= '0;
      else          comp <= comp_nxt;
   end

   // Composite keys reach the port read only; key_matrix stays purely physical.
   always_comb begin
      eff     = key_matrix;
      eff[0]  = key_matrix[0]  | (|comp);
      eff[23] = key_matrix[23] | comp[0];
      eff[24] = key_matrix[24] | comp[1];
      eff[19] = key_matrix[19] | comp[2];
      eff[22] = key_matrix[22] | comp[3];
      eff[20] = key_matrix[20] | comp[4];
   end

   assign event_nxt = (matrix_nxt != key_matrix) || (comp_nxt != comp);
`else
   assign eff       = key_matrix;
   assign event_nxt = (matrix_nxt != key_matrix);
`endif

   always_comb begin
      cols_nxt = '1;
      for (int unsigned r = 0; r < 8; r++) begin
         if (!addr_hi[r]) begin
            for (int unsigned c = 0; c < 5; c++) begin
               if (eff[r*5 + c]) cols_nxt[c] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_matrix <= '0;
         key_event  <= 1'b0;
         kb_cols    <= 5'h1F;
      end else begin
         key_matrix <= matrix_nxt;
         key_event  <= event_nxt;
         kb_cols    <= cols_nxt;
      end
   end

endmodule
